// File: rtl/hs_sequencer_if.sv
// Phase-select / symbol bus between the HS control FSM (master) and the
// HS symbol sequencer (slave).
interface hs_sequencer_if;
  logic       Sequencer_En;
  logic       Sync;
  logic       Post;
  logic       Pre_Done;
  logic       Sync_Done;
  logic       Post_Done;
  logic [2:0] SeqSym;

  modport master (
    output Sequencer_En, Sync, Post,
    input  Pre_Done, Sync_Done, Post_Done, SeqSym
  );

  modport slave (
    input  Sequencer_En, Sync, Post,
    output Pre_Done, Sync_Done, Post_Done, SeqSym
  );
endinterface

// File: rtl/hs_sequencer.sv
// C-PHY HS burst symbol sequencer: emits preamble, sync word or post symbols
// one per SymClk and raises a sticky per-phase done flag.
module hs_sequencer (
  input  logic     SymClk,
  input  logic     reset,
  hs_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PRE, SYNC, POST} phase_t;

  phase_t     phase_q, phase_d, req;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] sym_q, sym_d;
  logic [2:0] done_q, done_d;  // {pre, sync, post}

  function automatic logic [3:0] seq_len(phase_t p);
    case (p)
      PRE:        seq_len = 4'd13;
      SYNC, POST: seq_len = 4'd7;
      default:    seq_len = 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] seq_sym(phase_t p, logic [3:0] i);
    case (p)
      PRE:     seq_sym = 3'd3;
      SYNC:    seq_sym = (i == 4'd0 || i == 4'd6) ? 3'd3 : 3'd4;
      POST:    seq_sym = 3'd4;
      default: seq_sym = 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] done_bit(phase_t p);
    case (p)
      PRE:     done_bit = 3'b100;
      SYNC:    done_bit = 3'b010;
      POST:    done_bit = 3'b001;
      default: done_bit = 3'b000;
    endcase
  endfunction

  always_ff @(posedge SymClk or negedge reset) begin
    if (!reset) begin
      phase_q <= IDLE;
      cnt_q   <= 4'd0;
      sym_q   <= 3'd0;
      done_q  <= 3'b000;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      sym_q   <= sym_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    sym_d   = sym_q;
    done_d  = done_q;
    req     = bus.Sync ? SYNC : (bus.Post ? POST : PRE);
    if (!bus.Sequencer_En) begin
      phase_d = IDLE;
      cnt_d   = 4'd0;
      sym_d   = 3'd0;
      done_d  = 3'b000;
    end else if (req != phase_q) begin
      // Any change of requested phase restarts at symbol 0 and aborts the old one
      phase_d = req;
      cnt_d   = 4'd1;
      sym_d   = seq_sym(req, 4'd0);
      done_d  = 3'b000;
    end else if (cnt_q < seq_len(phase_q)) begin
      sym_d = seq_sym(phase_q, cnt_q);
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == seq_len(phase_q) - 4'd1)
        done_d = done_bit(phase_q);
    end
    // Once Count saturates at len, symbol and done flag simply hold
  end

  assign bus.SeqSym    = sym_q;
  assign bus.Pre_Done  = done_q[2];
  assign bus.Sync_Done = done_q[1];
  assign bus.Post_Done = done_q[0];
endmodule

// File: tb/tb_hs_sequencer.sv
// Scoreboard bench for hs_sequencer: expected {SeqSym, Pre, Sync, Post} is
// queued as each cycle's stimulus is driven and checked after the edge.
module tb_hs_sequencer;
  logic SymClk;
  logic reset;
  hs_sequencer_if bus ();

  hs_sequencer dut (.SymClk(SymClk), .reset(reset), .bus(bus));

  initial begin
    SymClk = 1'b0;
    forever #5 SymClk = ~SymClk;
  end

  typedef struct {
    string      tag;
    logic [5:0] v;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [2:0] SYNC_SEQ [7] = '{3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {bus.SeqSym, bus.Pre_Done, bus.Sync_Done, bus.Post_Done};
  endfunction

  always @(posedge SymClk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.tag, {26'd0, outs()}, {26'd0, e.v});
    end
  end

  // Called at a negedge: drive inputs for the next edge, queue its expected outputs
  task automatic step(input logic en, input logic sy, input logic po,
                      input logic [2:0] sym, input logic pd, input logic sd,
                      input logic od, input string tag);
    exp_t e;
    bus.Sequencer_En = en;
    bus.Sync         = sy;
    bus.Post         = po;
    e.tag = tag;
    e.v   = {sym, pd, sd, od};
    q.push_back(e);
    @(negedge SymClk);
  endtask

  task automatic run_sync(input logic po, input string tag);
    for (int k = 0; k < 7; k++)
      step(1'b1, 1'b1, po, SYNC_SEQ[k], 1'b0, (k == 6), 1'b0, $sformatf("%s[%0d]", tag, k));
  endtask

  task automatic idle(input int n, input logic sy, input logic po, input string tag);
    for (int k = 0; k < n; k++)
      step(1'b0, sy, po, 3'd0, 1'b0, 1'b0, 1'b0, $sformatf("%s[%0d]", tag, k));
  endtask

  initial begin
    reset            = 1'b0;
    bus.Sequencer_En = 1'b1;
    bus.Sync         = 1'b0;
    bus.Post         = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge SymClk);
      chk($sformatf("reset_hold[%0d]", k), {26'd0, outs()}, 32'd0);
    end
    bus.Sequencer_En = 1'b0;
    reset = 1'b1;

    // Preamble: 13 x 3, done on the 13th edge, then held
    for (int k = 0; k < 13; k++)
      step(1'b1, 1'b0, 1'b0, 3'd3, (k == 12), 1'b0, 1'b0, $sformatf("pre[%0d]", k));
    for (int k = 0; k < 4; k++)
      step(1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, $sformatf("pre_hold[%0d]", k));

    // Sync after preamble: Pre_Done clears on the first sync edge
    run_sync(1'b0, "pre_sync");
    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, $sformatf("sync_hold[%0d]", k));

    idle(30, 1'b1, 1'b0, "en_drop");
    run_sync(1'b0, "direct_sync");
    idle(2, 1'b0, 1'b0, "gap1");

    // Post sequence
    for (int k = 0; k < 7; k++)
      step(1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, (k == 6), $sformatf("post[%0d]", k));
    for (int k = 0; k < 2; k++)
      step(1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1, $sformatf("post_hold[%0d]", k));

    // Sync and Post together mean SYNC, restarting from a finished POST
    run_sync(1'b1, "sync_post");
    idle(5, 1'b0, 1'b1, "en0_post");

    // Preamble aborted at symbol 5 by Sync
    for (int k = 0; k < 5; k++)
      step(1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, $sformatf("pre_abort[%0d]", k));
    run_sync(1'b0, "pre_to_sync");
    idle(1, 1'b0, 1'b0, "gap2");

    // Reset asserted mid-SYNC clears outputs without waiting for an edge
    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b1, 1'b0, SYNC_SEQ[k], 1'b0, 1'b0, 1'b0, $sformatf("mid_sync[%0d]", k));
    chk("mid_sync_sym", {29'd0, bus.SeqSym}, 32'd4);
    reset = 1'b0;
    #1;
    chk("async_reset", {26'd0, outs()}, 32'd0);
    @(negedge SymClk);
    chk("reset_hold2", {26'd0, outs()}, 32'd0);
    reset = 1'b1;
    run_sync(1'b0, "after_reset");

    @(negedge SymClk);
    chk("queue_drain", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
